// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: cathode codes, state encoding and
// the decimal limit helper used for overflow detection.
package seg7_pkg;

  // Active-low cathodes, [0]=CA .. [6]=CG
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {StIdle, StConv} conv_state_e;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] code;
    code = SEG_BLANK;
    for (int k = 0; k < 10; k++) begin
      if (d == 4'(k)) code = SEG_DIGIT[k];
    end
    return code;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with load/busy/done handshake, a pending
// request register and an atomically updated display register.
module seg7_bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned W      = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock_100,
  input  logic                  reset,
  input  logic [W-1:0]          num,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned     CW    = $clog2(W);
  localparam longint unsigned LIMIT = pow10(DIGITS);

  conv_state_e         state_q, state_d;
  logic [W-1:0]        bin_q, bin_d, pend_q, pend_d, src;
  logic                pend_v_q, pend_v_d;
  logic [4*DIGITS-1:0] acc_q, acc_d, adj, disp_q, disp_d;
  logic                ovf_cap_q, ovf_cap_d, ovf_q, ovf_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                last, start;

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      acc_q     <= '0;
      disp_q    <= '0;
      ovf_cap_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      acc_q     <= acc_d;
      disp_q    <= disp_d;
      ovf_cap_q <= ovf_cap_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end

    last  = (state_q == StConv) && (cnt_q == CW'(W - 1));
    // A load arriving on the finishing edge is newer than anything already pending
    src   = load ? num : pend_q;
    start = (state_q == StIdle) ? load : (last && (load || pend_v_q));

    state_d   = state_q;
    bin_d     = bin_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    acc_d     = acc_q;
    disp_d    = disp_q;
    ovf_cap_d = ovf_cap_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;

    if (state_q == StConv) begin
      acc_d = {adj[4*DIGITS-2:0], bin_q[W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (load) begin
        pend_d   = num;
        pend_v_d = 1'b1;
      end
      if (last) begin
        disp_d  = acc_d;
        ovf_d   = ovf_cap_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end

    if (start) begin
      state_d   = StConv;
      bin_d     = src;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_cap_d = 64'(src) >= LIMIT;
      pend_v_d  = 1'b0;
    end
  end

  always_comb begin
    busy = (state_q == StConv);
    done = done_q;
    bcd  = disp_q;
    ovf  = ovf_q;
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed active-low 7-segment driver: sequential BCD conversion plus a registered digit
// scan with leading-zero blanking, decimal points and overflow dashes.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned W           = 14,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clock_100,
  input  logic              reset,
  input  logic [W-1:0]      num,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_en,
  output logic              busy,
  output logic              done,
  output logic [6:0]        controls,
  output logic              dp,
  output logic [7:0]        seg_ctrl
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] bcd;
  logic                ovf;

  seg7_bin2bcd_seq #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clock_100 (clock_100),
    .reset     (reset),
    .num       (num),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .ovf       (ovf)
  );

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        controls_q, controls_d;
  logic              dp_q, dp_d;
  logic [7:0]        seg_q, seg_d, anode;
  logic [DIGITS-1:0] lz_zero;
  logic [3:0]        nib;
  logic              tick, all_zero, dp_sel, blank_sel;

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      controls_q <= SEG_BLANK;
      dp_q       <= 1'b1;
      seg_q      <= 8'hFF;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      controls_q <= controls_d;
      dp_q       <= dp_d;
      seg_q      <= seg_d;
    end
  end

  always_comb begin
    tick    = (presc_q == PW'(REFRESH_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

    // lz_zero[i]: every nibble from i up to the top digit is zero
    all_zero = 1'b1;
    lz_zero  = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero   = all_zero && (bcd[4*i +: 4] == 4'd0);
      lz_zero[i] = all_zero;
    end

    nib       = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    anode     = 8'hFF;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        nib       = bcd[4*i +: 4];
        dp_sel    = dp_en[i];
        blank_sel = blank_lz && (i > 0) && lz_zero[i];
        anode[i]  = 1'b0;
      end
    end

    controls_d = controls_q;
    dp_d       = dp_q;
    seg_d      = seg_q;
    if (tick) begin
      controls_d = ovf ? SEG_DASH : (blank_sel ? SEG_BLANK : seg_decode(nib));
      dp_d       = ~dp_sel;
      seg_d      = anode;
    end
  end

  assign controls = controls_q;
  assign dp       = dp_q;
  assign seg_ctrl = seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: table vectors, random values against a decimal-arithmetic
// model, and hand sequences for pending loads, same-edge loads and reset.
module tb_seg7_scan_display;

  localparam int WA = 14, DA = 4, RA = 4;
  localparam int WB = 20, DB = 6, RB = 2;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WA-1:0] num_a = '0;
  logic          load_a = 1'b0, blz = 1'b0;
  logic [DA-1:0] dpe_a = '0;
  logic          busy_a, done_a, dp_a;
  logic [6:0]    ctl_a;
  logic [7:0]    seg_a;
  logic [WB-1:0] num_b = '0;
  logic          load_b = 1'b0;
  logic [DB-1:0] dpe_b = '0;
  logic          busy_b, done_b, dp_b;
  logic [6:0]    ctl_b;
  logic [7:0]    seg_b;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, busy_cnt_a = 0;
  int done_a_log[$], done_b_log[$];

  always #5 clk = ~clk;

  seg7_scan_display #(.W(WA), .DIGITS(DA), .REFRESH_DIV(RA)) u_dut_a (
    .clock_100 (clk), .reset (rst_n), .num (num_a), .load (load_a), .blank_lz (blz),
    .dp_en (dpe_a), .busy (busy_a), .done (done_a), .controls (ctl_a), .dp (dp_a),
    .seg_ctrl (seg_a)
  );

  seg7_scan_display #(.W(WB), .DIGITS(DB), .REFRESH_DIV(RB)) u_dut_b (
    .clock_100 (clk), .reset (rst_n), .num (num_b), .load (load_b), .blank_lz (blz),
    .dp_en (dpe_b), .busy (busy_b), .done (done_b), .controls (ctl_b), .dp (dp_b),
    .seg_ctrl (seg_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a) done_a_log.push_back(cyc);
    if (done_b) done_b_log.push_back(cyc);
    if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
  end

  typedef struct {
    logic [WA-1:0]    num;
    bit               blz;
    logic [DA-1:0]    dpe;
    logic [3:0][6:0]  exp_dig;  // [0] = ones digit
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  function automatic logic [7:0][6:0] model_digits(input longint unsigned v, input bit b,
                                                   input int nd);
    longint unsigned p, lim;
    logic [7:0][6:0] r;
    r = {56{1'b1}};
    p = 1;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    for (int i = 0; i < nd; i++) begin
      if (v >= lim) r[i] = 7'b0111111;
      else if (b && i > 0 && v < p) r[i] = 7'b1111111;
      else r[i] = SEG_TAB[int'((v / p) % 10)];
      p = p * 10;
    end
    return r;
  endfunction

  // Load pulse sampled by one posedge; t is the cycle number of that capture edge.
  task automatic pulse(input bit b, input longint unsigned v, output int t);
    @(negedge clk);
    if (b) begin num_b = v[WB-1:0]; load_b = 1'b1; end
    else   begin num_a = v[WA-1:0]; load_a = 1'b1; end
    @(posedge clk);
    #1 t = cyc;
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic wait_done(input bit b, input int target, input int bound);
    for (int k = 0; k < bound; k++) begin
      if ((b ? done_b_log.size() : done_a_log.size()) >= target) break;
      @(negedge clk);
      #1;
    end
    check(b ? "done_wait_b" : "done_wait_a", b ? done_b_log.size() : done_a_log.size(),
          target);
  endtask

  task automatic check_scan(input bit b, input logic [7:0][6:0] exp_dig,
                            input logic [7:0] dpe, input int ncyc);
    int nd, rd, d, prev;
    logic [7:0] sc, exp_sc;
    logic [6:0] ct;
    logic dv;
    nd = b ? DB : DA;
    rd = b ? RB : RA;
    prev = -1;
    repeat (rd + 1) @(negedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      sc = b ? seg_b : seg_a;
      ct = b ? ctl_b : ctl_a;
      dv = b ? dp_b : dp_a;
      d = -1;
      for (int j = 7; j >= 0; j--) if (!sc[j]) d = j;
      exp_sc = (d < 0) ? 8'hFE : ((d < nd) ? ~(8'd1 << d) : 8'hFF);
      check("anode", sc, exp_sc);
      if (d >= 0 && d < nd) begin
        check($sformatf("digit%0d", d), ct, exp_dig[d]);
        check($sformatf("dp%0d", d), dv, !dpe[d]);
        if (prev >= 0 && d != prev) check("scan_order", d, (prev + 1) % nd);
        prev = d;
      end
    end
  endtask

  task automatic first_tick(input string nm);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (seg_a != 8'hFF) break;
    end
    check(nm, seg_a, 8'hFE);
  endtask

  initial begin
    int t, t1, n0, b0;
    logic [WA-1:0] rv;
    longint unsigned rb;

    vecs[0] = '{14'd1234,  1'b0, 4'b0000, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{14'd7,     1'b1, 4'b0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
    vecs[2] = '{14'd7,     1'b0, 4'b0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}};
    vecs[3] = '{14'd10000, 1'b0, 4'b0100, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
    vecs[4] = '{14'd0,     1'b1, 4'b1001, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
    vecs[5] = '{14'd9999,  1'b1, 4'b0001, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
    vecs[6] = '{14'd305,   1'b1, 4'b0010, {7'b1111111, 7'b0110000, 7'b1000000, 7'b0010010}};
    vecs[7] = '{14'd16383, 1'b1, 4'b1111, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};

    #12;
    check("rst_controls", ctl_a, 7'h7F);
    check("rst_seg_ctrl", seg_a, 8'hFF);
    check("rst_dp", dp_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_seg_ctrl_b", seg_b, 8'hFF);
    @(negedge clk) rst_n = 1'b1;
    first_tick("first_tick");
    check_scan(0, model_digits(0, 0, DA), 8'h00, 16);

    for (int i = 0; i < 8; i++) begin
      blz = vecs[i].blz;
      dpe_a = vecs[i].dpe;
      n0 = done_a_log.size();
      b0 = busy_cnt_a;
      pulse(0, vecs[i].num, t);
      wait_done(0, n0 + 1, 40);
      if (done_a_log.size() > n0) check("latency", done_a_log[n0] - t + 1, WA + 1);
      check("busy_cycles", busy_cnt_a - b0, WA);
      check_scan(0, {{28{1'b1}}, vecs[i].exp_dig}, 8'(vecs[i].dpe), 2 * DA * RA);
    end

    for (int i = 0; i < 12; i++) begin
      rv = WA'($urandom_range(0, 16383));
      blz = 1'($urandom_range(0, 1));
      dpe_a = DA'($urandom_range(0, 15));
      n0 = done_a_log.size();
      pulse(0, rv, t);
      wait_done(0, n0 + 1, 40);
      if (done_a_log.size() > n0) check("rand_latency", done_a_log[n0] - t + 1, WA + 1);
      check_scan(0, model_digits(rv, blz, DA), 8'(dpe_a), 2 * DA * RA);
    end

    // Loads during busy: 42 completes, then only the latest (55) is converted.
    blz = 1'b0;
    dpe_a = '0;
    n0 = done_a_log.size();
    pulse(0, 42, t);
    repeat (2) @(negedge clk);
    pulse(0, 99, t1);
    pulse(0, 55, t1);
    wait_done(0, n0 + 1, 40);
    if (done_a_log.size() > n0) check("pend_first_lat", done_a_log[n0] - t + 1, WA + 1);
    check_scan(0, model_digits(42, 0, DA), 8'h00, 8);
    wait_done(0, n0 + 2, 40);
    if (done_a_log.size() > n0 + 1)
      check("pend_restart", done_a_log[n0 + 1] - done_a_log[n0], WA);
    check_scan(0, model_digits(55, 0, DA), 8'h00, 2 * DA * RA);
    repeat (40) @(negedge clk);
    #1 check("pend_no_extra_done", done_a_log.size(), n0 + 2);

    // Load sampled on the very edge the conversion finishes.
    n0 = done_a_log.size();
    pulse(0, 123, t);
    repeat (12) @(negedge clk);
    pulse(0, 456, t1);
    wait_done(0, n0 + 2, 60);
    if (done_a_log.size() > n0 + 1) begin
      check("edge_first_done", done_a_log[n0] - t, WA);
      check("edge_second_done", done_a_log[n0 + 1] - t, 2 * WA);
    end
    check_scan(0, model_digits(456, 0, DA), 8'h00, 2 * DA * RA);

    // Asynchronous reset mid-conversion with a pending request.
    blz = 1'b1;
    pulse(0, 5000, t);
    pulse(0, 77, t1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_controls", ctl_a, 7'h7F);
    check("async_seg_ctrl", seg_a, 8'hFF);
    check("async_dp", dp_a, 1'b1);
    check("async_busy", busy_a, 1'b0);
    n0 = done_a_log.size();
    @(negedge clk) rst_n = 1'b1;
    first_tick("post_rst_tick");
    repeat (40) @(negedge clk);
    #1 check("abort_no_done", done_a_log.size(), n0);
    check_scan(0, model_digits(0, 1, DA), 8'h00, 2 * DA * RA);

    // Six-digit instance.
    blz = 1'b0;
    dpe_b = 6'b100001;
    n0 = done_b_log.size();
    pulse(1, 999999, t);
    wait_done(1, n0 + 1, 60);
    if (done_b_log.size() > n0) check("b_latency", done_b_log[n0] - t + 1, WB + 1);
    check_scan(1, model_digits(999999, 0, DB), 8'(dpe_b), 3 * DB * RB);
    for (int i = 0; i < 5; i++) begin
      rb = longint'($urandom_range(0, 1048575));
      if (i == 0) rb = 1000000;
      blz = 1'($urandom_range(0, 1));
      dpe_b = DB'($urandom_range(0, 63));
      n0 = done_b_log.size();
      pulse(1, rb, t);
      wait_done(1, n0 + 1, 60);
      check_scan(1, model_digits(rb, blz, DB), 8'(dpe_b), 2 * DB * RB);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
